// File: rtl/bus_pkg.sv
// ---------------------------------------------------------------------------
// bus_pkg
// Shared types for the peripheral bus and its two-master arbiter.
//   Word_t      : 32-bit bus data/address word
//   ByteMask_t  : per-byte write enable for one word
//   ArbState_t  : grant FSM states (no owner, m0 owns, m1 owns)
//   MasterId_t  : identifies one of the two upstream masters
// ---------------------------------------------------------------------------
package bus_pkg;

  typedef logic [31:0] Word_t;
  typedef logic [3:0]  ByteMask_t;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } ArbState_t;

  typedef logic MasterId_t;

  localparam MasterId_t MASTER_M0 = 1'b0;
  localparam MasterId_t MASTER_M1 = 1'b1;

  // A master is asking for the bus whenever it drives either strobe.
  function automatic logic bus_req(input logic read, input logic write);
    return read | write;
  endfunction

endpackage

// File: rtl/bus_if.sv
// ---------------------------------------------------------------------------
// Bus_if
// Simple single-cycle-capable peripheral bus with slave-driven stall.
//   master side drives : address, read, write, data_wr, mask
//   slave side drives  : stall, data_rd, data_rd_2
// A transfer completes on a cycle where read|write is high and stall is low.
// ---------------------------------------------------------------------------
interface Bus_if;

  bus_pkg::Word_t     address;
  logic               read;
  logic               write;
  bus_pkg::Word_t     data_wr;
  bus_pkg::ByteMask_t mask;
  logic               stall;
  bus_pkg::Word_t     data_rd;
  bus_pkg::Word_t     data_rd_2;

  modport master (
    output address, read, write, data_wr, mask,
    input  stall, data_rd, data_rd_2
  );

  modport slave (
    input  address, read, write, data_wr, mask,
    output stall, data_rd, data_rd_2
  );

endinterface

// File: rtl/bus_watchdog.sv
// ---------------------------------------------------------------------------
// bus_watchdog
// Counts consecutive cycles in which the current bus owner is stalled by the
// downstream slave. The count saturates at WDOG_LIMIT and a sticky timeout
// flag is raised on the edge where the count reaches the limit. Only reset
// clears the flag.
// Ports:
//   clk     : system clock
//   rst_n   : synchronous active-low reset
//   busy    : owner is requesting and the slave is stalling this cycle
//   timeout : sticky watchdog flag
// ---------------------------------------------------------------------------
module bus_watchdog #(
  parameter int WDOG_LIMIT = 1024,
  parameter int WDOG_WIDTH = $clog2(WDOG_LIMIT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic busy,
  output logic timeout
);

  localparam logic [WDOG_WIDTH-1:0] LIMIT_C    = WDOG_WIDTH'(WDOG_LIMIT);
  localparam logic [WDOG_WIDTH-1:0] LIMIT_M1_C = WDOG_WIDTH'(WDOG_LIMIT - 1);

  logic [WDOG_WIDTH-1:0] count;

  // Any cycle that is not a stalled owner cycle (completion, idle owner, no
  // owner) restarts the count. The flag is set on the same edge the count
  // arrives at the limit, so it is visible right after the last stalled cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count   <= '0;
      timeout <= 1'b0;
    end else if (!busy) begin
      count <= '0;
    end else begin
      if (count != LIMIT_C) begin
        count <= count + WDOG_WIDTH'(1);
      end
      if (count >= LIMIT_M1_C) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_2m.sv
// ---------------------------------------------------------------------------
// bus_arbiter_2m
// Shares one downstream Bus_if slave between an instruction-fetch master (m0)
// and a data master (m1). A registered round-robin grant parks on the last
// owner and only moves at transfer boundaries; the non-owner is held off
// through its stall signal.
// Ports:
//   clk, rst_n  : clock and synchronous active-low reset
//   m0, m1      : upstream master ports (we act as their slave)
//   s           : shared downstream bus (we act as its master)
//   owner       : current grant, 0 = m0, 1 = m1
//   grant_valid : set once any master has been granted since reset
//   bus_timeout : sticky downstream-stall watchdog flag
// ---------------------------------------------------------------------------
module bus_arbiter_2m
  import bus_pkg::*;
#(
  parameter int WDOG_LIMIT = 1024,
  parameter int WDOG_WIDTH = $clog2(WDOG_LIMIT + 1)
) (
  input  logic  clk,
  input  logic  rst_n,
  Bus_if.slave  m0,
  Bus_if.slave  m1,
  Bus_if.master s,
  output logic  owner,
  output logic  grant_valid,
  output logic  bus_timeout
);

  ArbState_t state;
  ArbState_t state_next;
  logic      req0;
  logic      req1;
  logic      own_req;
  logic      own_busy;

  assign req0 = bus_req(m0.read, m0.write);
  assign req1 = bus_req(m1.read, m1.write);

  // The owner's request gates everything else: a stalled request is a
  // transfer in flight, anything else is a boundary where the grant may move.
  always_comb begin
    own_req = 1'b0;
    case (state)
      ARB_OWN0: own_req = req0;
      ARB_OWN1: own_req = req1;
      default:  own_req = 1'b0;
    endcase
  end

  assign own_busy = own_req & s.stall;

  // Next grant. From IDLE the data master wins a tie. From an owner state the
  // grant moves to the other master only when the owner is not mid-transfer,
  // which covers completion, an idle parked owner and an abandoned request.
  always_comb begin
    state_next = state;
    case (state)
      ARB_IDLE: begin
        if (req1)      state_next = ARB_OWN1;
        else if (req0) state_next = ARB_OWN0;
      end
      ARB_OWN0: begin
        if (!own_busy && req1) state_next = ARB_OWN1;
      end
      ARB_OWN1: begin
        if (!own_busy && req0) state_next = ARB_OWN0;
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  // Grant registers. owner and grant_valid are registered alongside the state
  // so they change on exactly the same edge as the grant itself.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ARB_IDLE;
      owner       <= MASTER_M0;
      grant_valid <= 1'b0;
    end else begin
      state <= state_next;
      owner <= (state_next == ARB_OWN1) ? MASTER_M1 : MASTER_M0;
      if (state_next != ARB_IDLE) begin
        grant_valid <= 1'b1;
      end
    end
  end

  // Bus steering from the registered grant. The owner is wired straight to
  // the slave so a parked owner pays no extra latency; a non-owner just sees
  // its own request reflected back as stall.
  always_comb begin
    s.address    = '0;
    s.read       = 1'b0;
    s.write      = 1'b0;
    s.data_wr    = '0;
    s.mask       = '0;
    m0.stall     = req0;
    m0.data_rd   = '0;
    m0.data_rd_2 = '0;
    m1.stall     = req1;
    m1.data_rd   = '0;
    m1.data_rd_2 = '0;
    case (state)
      ARB_OWN0: begin
        s.address    = m0.address;
        s.read       = m0.read;
        s.write      = m0.write;
        s.data_wr    = m0.data_wr;
        s.mask       = m0.mask;
        m0.stall     = s.stall;
        m0.data_rd   = s.data_rd;
        m0.data_rd_2 = s.data_rd_2;
      end
      ARB_OWN1: begin
        s.address    = m1.address;
        s.read       = m1.read;
        s.write      = m1.write;
        s.data_wr    = m1.data_wr;
        s.mask       = m1.mask;
        m1.stall     = s.stall;
        m1.data_rd   = s.data_rd;
        m1.data_rd_2 = s.data_rd_2;
      end
      default: ;
    endcase
  end

  bus_watchdog #(
    .WDOG_LIMIT(WDOG_LIMIT),
    .WDOG_WIDTH(WDOG_WIDTH)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .busy   (own_busy),
    .timeout(bus_timeout)
  );

endmodule
